// File: rtl/wu_task_sequencer_pkg.sv
// Shared types and defaults for the work-unit task sequencer.
// MAX_VERTSBITS / MAX_PROBSBITS may be predefined by the surrounding build.
`ifndef MAX_VERTSBITS
`define MAX_VERTSBITS 4
`endif
`ifndef MAX_PROBSBITS
`define MAX_PROBSBITS 4
`endif

package wu_task_sequencer_pkg;
   localparam int WU_VERTS_W    = `MAX_VERTSBITS;
   localparam int WU_PROBS_W    = `MAX_PROBSBITS;
   localparam int WU_PIPE_DEPTH = 8;
   localparam int WU_CNT_W      = 4;

   typedef enum logic [1:0] {
      WU_S_IDLE  = 2'd0,
      WU_S_ISSUE = 2'd1,
      WU_S_DRAIN = 2'd2,
      WU_S_DONE  = 2'd3
   } wu_state_e;

   // Saturating increment used by the optional cycle counter.
   function automatic logic [31:0] wu_sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
   endfunction
endpackage

// File: rtl/wu_loop_counter.sv
// Three nested k/i/j wrap counters (j fastest) with a registered last-op flag.
// Limit compare happens before increment so limit = all-ones never overflows.
module wu_loop_counter
   import wu_task_sequencer_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_limit,
   input  logic         i_en,
   output logic [W-1:0] o_k,
   output logic [W-1:0] o_i,
   output logic [W-1:0] o_j,
   output logic         o_last
);
   logic [W-1:0] lim_q;
   logic [W-1:0] k_d;
   logic [W-1:0] i_d;
   logic [W-1:0] j_d;
   logic         last_d;

   // Next index triple; the walk freezes once the last op has been reached.
   always_comb begin
      k_d    = o_k;
      i_d    = o_i;
      j_d    = o_j;
      last_d = o_last;
      if (i_load) begin
         k_d    = {W{1'b0}};
         i_d    = {W{1'b0}};
         j_d    = {W{1'b0}};
         last_d = (i_limit == {W{1'b0}});
      end else if (i_en && !o_last) begin
         if (o_j != lim_q) begin
            j_d = o_j + W'(1'b1);
         end else begin
            j_d = {W{1'b0}};
            if (o_i != lim_q) begin
               i_d = o_i + W'(1'b1);
            end else begin
               i_d = {W{1'b0}};
               k_d = o_k + W'(1'b1);
            end
         end
         last_d = (k_d == lim_q) && (i_d == lim_q) && (j_d == lim_q);
      end else begin
         last_d = o_last;
      end
   end

   // Index, limit and last-flag registers.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         lim_q  <= {W{1'b0}};
         o_k    <= {W{1'b0}};
         o_i    <= {W{1'b0}};
         o_j    <= {W{1'b0}};
         o_last <= 1'b0;
      end else begin
         if (i_load) begin
            lim_q <= i_limit;
         end
         o_k    <= k_d;
         o_i    <= i_d;
         o_j    <= j_d;
         o_last <= last_d;
      end
   end
endmodule

// File: rtl/wu_task_sequencer.sv
// Work-unit side of the scheduler dispatch: walks the k/i/j loop, throttles on
// in-flight ops, drains and pulses done. WU_PERF_CNT_EN adds o_perf_cycles.
module wu_task_sequencer
   import wu_task_sequencer_pkg::*;
#(
   parameter int VERTS_W    = WU_VERTS_W,
   parameter int PROBS_W    = WU_PROBS_W,
   parameter int PIPE_DEPTH = WU_PIPE_DEPTH,
   parameter int CNT_W      = WU_CNT_W
) (
   input  logic               i_clk300,
   input  logic               i_reset_n,
   input  logic               i_go,
   input  logic [VERTS_W-1:0] i_nverts,
   input  logic [PROBS_W-1:0] i_prob_no,
   output logic               o_busy,
   output logic               o_op_valid,
   input  logic               i_op_ready,
   output logic [VERTS_W-1:0] o_op_k,
   output logic [VERTS_W-1:0] o_op_i,
   output logic [VERTS_W-1:0] o_op_j,
   output logic [PROBS_W-1:0] o_op_prob,
   output logic               o_op_last,
   input  logic               i_res_valid,
   output logic               o_done,
   output logic [PROBS_W-1:0] o_done_prob
`ifdef WU_PERF_CNT_EN
   ,
   output logic [31:0]        o_perf_cycles
`endif
);
   wu_state_e          state_q;
   logic [CNT_W-1:0]   outst_q;
   logic [CNT_W-1:0]   outst_d;
   logic               issue_s;
   logic               retire_s;
   logic               go_ok_s;
   logic               cnt_load_s;
   logic [VERTS_W-1:0] limit_s;

   // Handshake decode and in-flight bookkeeping; a retire with nothing in flight is dropped.
   always_comb begin
      issue_s    = o_op_valid & i_op_ready;
      retire_s   = i_res_valid & (outst_q != {CNT_W{1'b0}});
      go_ok_s    = i_go & (state_q == WU_S_IDLE);
      cnt_load_s = go_ok_s & (i_nverts != {VERTS_W{1'b0}});
      limit_s    = i_nverts - VERTS_W'(1'b1);
      if (issue_s && !retire_s) begin
         outst_d = outst_q + CNT_W'(1'b1);
      end else if (!issue_s && retire_s) begin
         outst_d = outst_q - CNT_W'(1'b1);
      end else begin
         outst_d = outst_q;
      end
   end

   wu_loop_counter #(
      .W (VERTS_W)
   ) u_loop (
      .i_clk     (i_clk300),
      .i_reset_n (i_reset_n),
      .i_load    (cnt_load_s),
      .i_limit   (limit_s),
      .i_en      (issue_s),
      .o_k       (o_op_k),
      .o_i       (o_op_i),
      .o_j       (o_op_j),
      .o_last    (o_op_last)
   );

   // Sequencer FSM with registered handshake and status outputs.
   always_ff @(posedge i_clk300) begin
      if (!i_reset_n) begin
         state_q     <= WU_S_IDLE;
         outst_q     <= {CNT_W{1'b0}};
         o_busy      <= 1'b0;
         o_op_valid  <= 1'b0;
         o_op_prob   <= {PROBS_W{1'b0}};
         o_done      <= 1'b0;
         o_done_prob <= {PROBS_W{1'b0}};
      end else begin
         outst_q <= outst_d;
         case (state_q)
            WU_S_IDLE: begin
               o_done <= 1'b0;
               if (i_go) begin
                  o_busy    <= 1'b1;
                  o_op_prob <= i_prob_no;
                  if (i_nverts == {VERTS_W{1'b0}}) begin
                     state_q     <= WU_S_DONE;
                     o_done      <= 1'b1;
                     o_done_prob <= i_prob_no;
                     o_op_valid  <= 1'b0;
                  end else begin
                     state_q    <= WU_S_ISSUE;
                     o_op_valid <= 1'b1;
                  end
               end
            end
            WU_S_ISSUE: begin
               if (issue_s && o_op_last) begin
                  state_q    <= WU_S_DRAIN;
                  o_op_valid <= 1'b0;
               end else begin
                  // Valid only falls here when the pipe has just filled.
                  o_op_valid <= (outst_d != CNT_W'(PIPE_DEPTH));
               end
            end
            WU_S_DRAIN: begin
               if (outst_d == {CNT_W{1'b0}}) begin
                  state_q     <= WU_S_DONE;
                  o_done      <= 1'b1;
                  o_done_prob <= o_op_prob;
               end
            end
            WU_S_DONE: begin
               state_q <= WU_S_IDLE;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
            end
            default: begin
               state_q    <= WU_S_IDLE;
               o_busy     <= 1'b0;
               o_op_valid <= 1'b0;
               o_done     <= 1'b0;
            end
         endcase
      end
   end

`ifdef WU_PERF_CNT_EN
   logic [31:0] perf_q;

   // Busy-cycle counter: cleared by an accepted go, frozen while idle.
   always_ff @(posedge i_clk300) begin
      if (!i_reset_n) begin
         perf_q <= 32'd0;
      end else if (go_ok_s) begin
         perf_q <= 32'd0;
      end else if (state_q != WU_S_IDLE) begin
         perf_q <= wu_sat_inc32(perf_q);
      end
   end

   assign o_perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_wu_task_sequencer.sv
// Scoreboard bench for wu_task_sequencer: a nested-loop reference model fills
// expected-op/done queues; a monitor compares every presented op and done pulse.
module tb_wu_task_sequencer;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [3:0] k;
      logic [3:0] i;
      logic [3:0] j;
      logic [3:0] prob;
      logic       last;
   } op_t;

   logic        clk;
   logic        rst_n;
   logic        go;
   logic [3:0]  nverts;
   logic [3:0]  prob;
   logic        busy;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_k;
   logic [3:0]  op_i;
   logic [3:0]  op_j;
   logic [3:0]  op_prob;
   logic        op_last;
   logic        res_valid;
   logic        done;
   logic [3:0]  done_prob;
`ifdef WU_PERF_CNT_EN
   logic [31:0] perf;
`endif

   op_t        exp_q[$];
   logic [3:0] done_q[$];
   bit         zero_q[$];
   int         ret_q[$];

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int out_m = 0;
   int issued_total = 0;
   int done_cnt = 0;
   int last_ret = 0;
   bit after_done = 0;
   bit res_en = 1;
   int res_budget = 0;
   bit rdy_rand = 0;
   bit lat_rand = 0;
   int lat_fix = 3;
   int stall_at = -1;

   wu_task_sequencer dut (
      .i_clk300    (clk),
      .i_reset_n   (rst_n),
      .i_go        (go),
      .i_nverts    (nverts),
      .i_prob_no   (prob),
      .o_busy      (busy),
      .o_op_valid  (op_valid),
      .i_op_ready  (op_ready),
      .o_op_k      (op_k),
      .o_op_i      (op_i),
      .o_op_j      (op_j),
      .o_op_prob   (op_prob),
      .o_op_last   (op_last),
      .i_res_valid (res_valid),
      .o_done      (done),
      .o_done_prob (done_prob)
`ifdef WU_PERF_CNT_EN
      ,
      .o_perf_cycles (perf)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: k outer, i middle, j inner; last at the very final triple.
   task automatic do_go(input int nv, input int pr);
      @(posedge clk); #1;
      go = 1'b1; nverts = 4'(nv); prob = 4'(pr);
      @(posedge clk); #1;
      go = 1'b0;
      for (int k = 0; k < nv; k++)
         for (int i = 0; i < nv; i++)
            for (int j = 0; j < nv; j++) begin
               op_t o;
               o.k = 4'(k); o.i = 4'(i); o.j = 4'(j); o.prob = 4'(pr);
               o.last = (k == nv - 1) && (i == nv - 1) && (j == nv - 1);
               exp_q.push_back(o);
            end
      done_q.push_back(4'(pr));
      zero_q.push_back(nv == 0);
   endtask

   task automatic wait_done(input int target);
      for (int n = 0; n < 20000 && done_cnt < target; n++) @(negedge clk);
      chk("done_timeout", 32'(done_cnt >= target), 32'd1);
   endtask

   // Datapath stand-in: drives ready (with optional stall window) and retires.
   initial begin : driver
      int stall_cnt;
      int rel_used;
      stall_cnt = 0;
      rel_used = 0;
      op_ready = 1'b0;
      res_valid = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (issued_total == stall_at && stall_cnt < 5) begin
            op_ready = 1'b0;
            stall_cnt++;
         end else begin
            if (issued_total != stall_at) stall_cnt = 0;
            op_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         res_valid = 1'b0;
         if (ret_q.size() > 0 && ret_q[0] <= cyc && (res_en || rel_used < res_budget)) begin
            void'(ret_q.pop_front());
            res_valid = 1'b1;
            if (!res_en) rel_used++;
         end
      end
   end

   // Monitor: checks valid/throttle, op contents, done pulses against the model.
   initial begin : monitor
      op_t        e;
      logic [3:0] p;
      bit         z;
      bit         issue;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            exp_q.delete(); done_q.delete(); zero_q.delete(); ret_q.delete();
            out_m = 0;
            after_done = 0;
         end else begin
            if (after_done) begin
               chk("busy_after_done", 32'(busy), 32'd0);
               after_done = 0;
            end
            chk("op_valid", 32'(op_valid), 32'(exp_q.size() > 0 && out_m < DEPTH));
            if (op_valid && exp_q.size() > 0) begin
               e = exp_q[0];
               chk("op_fields", 32'({op_k, op_i, op_j, op_prob, op_last}), 32'(e));
            end
            issue = op_valid & op_ready;
            if (issue && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               issued_total++;
               ret_q.push_back(cyc + (lat_rand ? int'($urandom_range(1, 6)) : lat_fix));
            end
            if (res_valid) begin
               if (out_m > 0) out_m--;
               last_ret = cyc;
            end
            if (issue) out_m++;
            if (done) begin
               chk("done_expected", 32'(done_q.size() > 0), 32'd1);
               if (done_q.size() > 0) begin
                  p = done_q.pop_front();
                  z = zero_q.pop_front();
                  chk("done_prob", 32'(done_prob), 32'(p));
                  chk("done_drained", 32'(exp_q.size() + out_m), 32'd0);
                  if (!z) chk("done_latency", 32'(cyc), 32'(last_ret + 1));
                  done_cnt++;
                  after_done = 1;
               end
            end
         end
      end
   end

   initial begin : main
      int base;
      int n_exp;
      int nv;
      int pr;
      rst_n = 1'b0; go = 1'b0; nverts = 4'd0; prob = 4'd0;
      n_exp = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'({busy, op_valid, op_k, op_i, op_j, op_prob, op_last, done, done_prob}), 32'd0);
`ifdef WU_PERF_CNT_EN
      chk("reset_perf", perf, 32'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;

      // nverts=2, fixed latency 3
      do_go(2, 3);
      @(negedge clk);
      chk("busy_at_go1", 32'(busy), 32'd1);
      chk("valid_at_go1", 32'(op_valid), 32'd1);
      wait_done(++n_exp);

      // nverts=0, plus a go landing in DONE that must be ignored
      @(posedge clk); #1;
      go = 1'b1; nverts = 4'd0; prob = 4'd5;
      @(posedge clk); #1;
      done_q.push_back(4'd5); zero_q.push_back(1'b1); n_exp++;
      go = 1'b1; nverts = 4'd2; prob = 4'd9;
      @(negedge clk);
      chk("nv0_busy", 32'(busy), 32'd1);
      chk("nv0_done", 32'(done), 32'd1);
      chk("nv0_done_prob", 32'(done_prob), 32'd5);
      @(posedge clk); #1;
      go = 1'b0;
      @(negedge clk);
      chk("nv0_busy_fall", 32'(busy), 32'd0);
      chk("nv0_done_fall", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      chk("nv0_prob_held", 32'(op_prob), 32'd5);
`ifdef WU_PERF_CNT_EN
      chk("perf_nv0", perf, 32'd1);
`endif
      wait_done(n_exp);

      // nverts=3 with a 5-cycle ready stall at op 10
      base = issued_total;
      stall_at = base + 9;
      do_go(3, 6);
      wait_done(++n_exp);
      chk("stall_op_count", 32'(issued_total - base), 32'd27);
      stall_at = -1;

      // throttle: hold retires, then release two
      res_en = 1'b0;
      base = issued_total;
      do_go(3, 10);
      repeat (30) @(negedge clk);
      chk("throttle_count", 32'(issued_total - base), 32'd8);
      res_budget = 2;
      repeat (10) @(negedge clk);
      chk("throttle_release", 32'(issued_total - base), 32'd10);
      res_en = 1'b1;
      wait_done(++n_exp);

      // reset mid-ISSUE, then a fresh problem
      base = issued_total;
      do_go(3, 7);
      for (int n = 0; n < 200 && issued_total < base + 5; n++) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_quiet", 32'({busy, op_valid, done}), 32'd0);
      repeat (5) @(negedge clk);
      chk("midrst_no_done", 32'(done_cnt), 32'(n_exp));
      do_go(2, 11);
      wait_done(++n_exp);

      // largest nverts: indices must reach all-ones without wrapping
      lat_fix = 2;
      base = issued_total;
      do_go(15, 12);
      wait_done(++n_exp);
      chk("max_op_count", 32'(issued_total - base), 32'd3375);

      // randomized problems with random ready/latency and stray go while busy
      rdy_rand = 1'b1;
      lat_rand = 1'b1;
      for (int n = 0; n < 10; n++) begin
         nv = int'($urandom_range(0, 3));
         pr = int'($urandom_range(0, 15));
         do_go(nv, pr);
         if (nv >= 2) begin
            repeat (3) @(posedge clk); #1;
            go = 1'b1; nverts = 4'($urandom_range(0, 15)); prob = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            go = 1'b0;
         end
         wait_done(++n_exp);
         repeat (2) @(posedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
